pipeline_memory_writeback: RTL and testbench

Memory stage plus MEM/WB pipeline register of the five-stage pipeline. Consumes the EX/MEM latch outputs, drives the data-side cache request, stalls the pipeline until the access completes, and registers the writeback word, destination and control for the WB stage. It also keeps a sticky halt and a saturating count of memory-stall cycles.

---
 rtl/pipeline_memory_writeback.sv | 146 ++++++++++++++
 tb/tb_pipeline_memory_writeback.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_memory_writeback.sv
// Memory stage and MEM/WB pipeline register.
// Holds the front of the pipe on data-cache misses and registers the writeback word.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;
endpackage

module pipeline_memory_writeback
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dREN_mem,
  input  logic        dWEN_mem,
  input  logic        MemToReg_mem,
  input  logic        jal_mem,
  input  logic        RegWrite_mem,
  input  logic        halt_mem,
  input  logic [31:0] port_o_mem,
  input  logic [31:0] rdat2_mem,
  input  logic [31:0] pc4_mem,
  input  logic [4:0]  regWSEL_mem,
  input  logic        mw_hold,
  input  logic        mw_flush,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
  output logic        RegWrite_wb,
  output logic        halt_wb,
  output logic [31:0] wdat_wb,
  output logic [4:0]  regWSEL_wb,
  output logic [31:0] stall_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  logic [1:0] state, nstate;
  logic       mop, done, halted;
  logic       cap, ld_en;
  word_t      ldbuf, wword;

  assign mop    = dREN_mem | dWEN_mem;
  assign done   = (state == DONE);
  assign halted = (state == HALTED);

  // DONE drops the request so a completed store is not reissued
  assign dmemREN   = dREN_mem & ~done & ~halted;
  assign dmemWEN   = dWEN_mem & ~done & ~halted;
  assign dmemaddr  = port_o_mem;
  assign dmemstore = rdat2_mem;
  assign mem_stall = mop & ~dhit & ~done & ~halted;

  assign cap = ~mw_flush & ~mw_hold & ~mem_stall;

  always_comb begin
    wword = port_o_mem;
    if (jal_mem)
      wword = pc4_mem;
    else if (MemToReg_mem)
      wword = done ? ldbuf : dmemload;
  end

  always_comb begin
    nstate = state;
    ld_en  = 1'b0;
    if (!halted && cap && halt_mem) begin
      nstate = HALTED;
    end else begin
      unique case (state)
        IDLE: begin
          if (mop && !dhit) begin
            nstate = WAIT;
          end else if (mop && dhit && mw_hold) begin
            nstate = DONE;
            ld_en  = 1'b1;
          end
        end
        WAIT: begin
          if (dhit && !mw_hold) begin
            nstate = IDLE;
          end else if (dhit && mw_hold) begin
            nstate = DONE;
            ld_en  = 1'b1;
          end
        end
        DONE: begin
          if (!mw_hold)
            nstate = IDLE;
        end
        HALTED: nstate = HALTED;
        default: nstate = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      ldbuf <= '0;
    end else begin
      state <= nstate;
      if (ld_en)
        ldbuf <= dmemload;
    end
  end

  // halt_wb is sticky: bubbles and flushes never clear it
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      RegWrite_wb <= 1'b0;
      halt_wb     <= 1'b0;
      wdat_wb     <= '0;
      regWSEL_wb  <= '0;
    end else if (mw_flush) begin
      RegWrite_wb <= 1'b0;
      wdat_wb     <= '0;
      regWSEL_wb  <= '0;
    end else if (mw_hold) begin
      RegWrite_wb <= RegWrite_wb;
    end else if (mem_stall) begin
      RegWrite_wb <= 1'b0;
      wdat_wb     <= '0;
      regWSEL_wb  <= '0;
    end else begin
      RegWrite_wb <= RegWrite_mem;
      halt_wb     <= halt_wb | halt_mem;
      wdat_wb     <= wword;
      regWSEL_wb  <= regWSEL_mem;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      stall_cnt <= '0;
    else if (mem_stall && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end

endmodule

// File: tb/tb_pipeline_memory_writeback.sv
// Directed bench for pipeline_memory_writeback.
// Each task drives one scenario and checks its own results inline.
module tb_pipeline_memory_writeback;

  logic        CLK, nRST;
  logic        dREN_mem, dWEN_mem, MemToReg_mem, jal_mem;
  logic        RegWrite_mem, halt_mem;
  logic [31:0] port_o_mem, rdat2_mem, pc4_mem;
  logic [4:0]  regWSEL_mem;
  logic        mw_hold, mw_flush, dhit;
  logic [31:0] dmemload;
  logic        dmemREN, dmemWEN, mem_stall;
  logic [31:0] dmemaddr, dmemstore;
  logic        RegWrite_wb, halt_wb;
  logic [31:0] wdat_wb, stall_cnt;
  logic [4:0]  regWSEL_wb;

  int n_cmp = 0;
  int n_bad = 0;

  pipeline_memory_writeback dut (
    .CLK(CLK), .nRST(nRST),
    .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem),
    .MemToReg_mem(MemToReg_mem), .jal_mem(jal_mem),
    .RegWrite_mem(RegWrite_mem), .halt_mem(halt_mem),
    .port_o_mem(port_o_mem), .rdat2_mem(rdat2_mem),
    .pc4_mem(pc4_mem), .regWSEL_mem(regWSEL_mem),
    .mw_hold(mw_hold), .mw_flush(mw_flush),
    .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall),
    .RegWrite_wb(RegWrite_wb), .halt_wb(halt_wb),
    .wdat_wb(wdat_wb), .regWSEL_wb(regWSEL_wb),
    .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    dREN_mem = 0; dWEN_mem = 0; MemToReg_mem = 0; jal_mem = 0;
    RegWrite_mem = 0; halt_mem = 0;
    port_o_mem = 0; rdat2_mem = 0; pc4_mem = 0; regWSEL_mem = 0;
    mw_hold = 0; mw_flush = 0; dhit = 0; dmemload = 0;
  endtask

  task automatic test_reset();
    clr();
    nRST = 0;
    dREN_mem = 1;
    #2;
    n_cmp++;
    if (RegWrite_wb !== 1'b0 || halt_wb !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctl: rw=%b halt=%b want 0 0", RegWrite_wb, halt_wb);
    end
    n_cmp++;
    if (wdat_wb !== 32'h0 || regWSEL_wb !== 5'd0 || stall_cnt !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_data: wdat=%h sel=%0d cnt=%h want 0", wdat_wb, regWSEL_wb, stall_cnt);
    end
    n_cmp++;
    if (dmemREN !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ren: got %b want 1", dmemREN);
    end
    step();
    nRST = 1;
    clr();
    step();
  endtask

  task automatic test_load_hit();
    clr();
    dREN_mem = 1; MemToReg_mem = 1; RegWrite_mem = 1;
    port_o_mem = 32'h100; regWSEL_mem = 5'd8;
    dhit = 1; dmemload = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if (dmemREN !== 1'b1 || dmemaddr !== 32'h100 || mem_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL hit_req: ren=%b addr=%h stall=%b want 1 100 0", dmemREN, dmemaddr, mem_stall);
    end
    step();
    n_cmp++;
    if (wdat_wb !== 32'hDEADBEEF || regWSEL_wb !== 5'd8 || RegWrite_wb !== 1'b1) begin
      n_bad++;
      $display("FAIL hit_wb: wdat=%h sel=%0d rw=%b want deadbeef 8 1", wdat_wb, regWSEL_wb, RegWrite_wb);
    end
    n_cmp++;
    if (stall_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL hit_cnt: got %0d want 0", stall_cnt);
    end
    clr();
  endtask

  task automatic test_store_miss();
    int wen = 0;
    int stl = 0;
    clr();
    dWEN_mem = 1; rdat2_mem = 32'h1234; port_o_mem = 32'h200;
    for (int i = 0; i < 4; i++) begin
      dhit = (i == 3);
      #1;
      wen += int'(dmemWEN);
      stl += int'(mem_stall);
      if (i == 0) begin
        n_cmp++;
        if (dmemstore !== 32'h1234) begin
          n_bad++;
          $display("FAIL st_data: got %h want 1234", dmemstore);
        end
      end
      step();
      if (i < 3) begin
        n_cmp++;
        if (RegWrite_wb !== 1'b0 || wdat_wb !== 32'h0) begin
          n_bad++;
          $display("FAIL st_bubble%0d: rw=%b wdat=%h want 0 0", i, RegWrite_wb, wdat_wb);
        end
      end
    end
    n_cmp++;
    if (wen != 4 || stl != 3) begin
      n_bad++;
      $display("FAIL st_counts: wen=%0d stall=%0d want 4 3", wen, stl);
    end
    n_cmp++;
    if (stall_cnt !== 32'd3 || wdat_wb !== 32'h200) begin
      n_bad++;
      $display("FAIL st_done: cnt=%0d wdat=%h want 3 200", stall_cnt, wdat_wb);
    end
    clr();
  endtask

  task automatic test_hold_hit();
    clr();
    dREN_mem = 1; MemToReg_mem = 1; RegWrite_mem = 1;
    regWSEL_mem = 5'd5; port_o_mem = 32'h300;
    step();
    dhit = 1; dmemload = 32'hCAFEF00D; mw_hold = 1;
    #1;
    n_cmp++;
    if (dmemREN !== 1'b1 || mem_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL hh_hit: ren=%b stall=%b want 1 0", dmemREN, mem_stall);
    end
    step();
    dhit = 0; dmemload = 32'h0BADBAD0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (dmemREN !== 1'b0 || dmemWEN !== 1'b0 || mem_stall !== 1'b0) begin
        n_bad++;
        $display("FAIL hh_done%0d: ren=%b wen=%b stall=%b want 0 0 0", i, dmemREN, dmemWEN, mem_stall);
      end
      step();
    end
    n_cmp++;
    if (wdat_wb !== 32'h0) begin
      n_bad++;
      $display("FAIL hh_held: wdat=%h want 0", wdat_wb);
    end
    mw_hold = 0;
    #1;
    n_cmp++;
    if (dmemREN !== 1'b0 || mem_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL hh_release: ren=%b stall=%b want 0 0", dmemREN, mem_stall);
    end
    step();
    n_cmp++;
    if (wdat_wb !== 32'hCAFEF00D || regWSEL_wb !== 5'd5 || stall_cnt !== 32'd4) begin
      n_bad++;
      $display("FAIL hh_wb: wdat=%h sel=%0d cnt=%0d want cafef00d 5 4", wdat_wb, regWSEL_wb, stall_cnt);
    end
    clr();
  endtask

  task automatic test_jal_alu();
    clr();
    jal_mem = 1; pc4_mem = 32'h44; RegWrite_mem = 1;
    regWSEL_mem = 5'd31; port_o_mem = 32'h999;
    step();
    n_cmp++;
    if (wdat_wb !== 32'h44 || regWSEL_wb !== 5'd31) begin
      n_bad++;
      $display("FAIL jal: wdat=%h sel=%0d want 44 31", wdat_wb, regWSEL_wb);
    end
    jal_mem = 0; port_o_mem = 32'h7; regWSEL_mem = 5'd3;
    dhit = 1; dmemload = 32'h55555555;
    #1;
    n_cmp++;
    if (mem_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL alu_stall: got %b want 0", mem_stall);
    end
    step();
    n_cmp++;
    if (wdat_wb !== 32'h7 || regWSEL_wb !== 5'd3) begin
      n_bad++;
      $display("FAIL alu: wdat=%h sel=%0d want 7 3", wdat_wb, regWSEL_wb);
    end
    clr();
    dhit = 1; mw_hold = 1;
    step();
    clr();
    dWEN_mem = 1;
    #1;
    n_cmp++;
    if (dmemWEN !== 1'b1 || mem_stall !== 1'b1) begin
      n_bad++;
      $display("FAIL nomop_hit: wen=%b stall=%b want 1 1", dmemWEN, mem_stall);
    end
    step();
    dhit = 1;
    step();
    clr();
  endtask

  task automatic test_flush_dhit();
    clr();
    dREN_mem = 1; MemToReg_mem = 1; RegWrite_mem = 1;
    regWSEL_mem = 5'd9; dmemload = 32'h77;
    step();
    dhit = 1; mw_flush = 1;
    step();
    n_cmp++;
    if (RegWrite_wb !== 1'b0 || wdat_wb !== 32'h0 || regWSEL_wb !== 5'd0) begin
      n_bad++;
      $display("FAIL flush_hit: rw=%b wdat=%h sel=%0d want 0 0 0", RegWrite_wb, wdat_wb, regWSEL_wb);
    end
    n_cmp++;
    if (stall_cnt !== 32'd6) begin
      n_bad++;
      $display("FAIL flush_cnt: got %0d want 6", stall_cnt);
    end
    clr();
  endtask

  task automatic test_flush_done();
    clr();
    dREN_mem = 1; MemToReg_mem = 1; RegWrite_mem = 1;
    regWSEL_mem = 5'd10; dhit = 1; dmemload = 32'hA5A5; mw_hold = 1;
    step();
    mw_hold = 0; mw_flush = 1; dhit = 0;
    #1;
    n_cmp++;
    if (dmemREN !== 1'b0 || mem_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL fd_req: ren=%b stall=%b want 0 0", dmemREN, mem_stall);
    end
    step();
    n_cmp++;
    if (RegWrite_wb !== 1'b0 || wdat_wb !== 32'h0) begin
      n_bad++;
      $display("FAIL fd_bubble: rw=%b wdat=%h want 0 0", RegWrite_wb, wdat_wb);
    end
    clr();
    dWEN_mem = 1;
    #1;
    n_cmp++;
    if (dmemWEN !== 1'b1) begin
      n_bad++;
      $display("FAIL fd_idle: wen=%b want 1", dmemWEN);
    end
    step();
    dhit = 1;
    step();
    n_cmp++;
    if (stall_cnt !== 32'd7) begin
      n_bad++;
      $display("FAIL fd_cnt: got %0d want 7", stall_cnt);
    end
    clr();
  endtask

  task automatic test_halt();
    clr();
    halt_mem = 1; RegWrite_mem = 1; regWSEL_mem = 5'd2; port_o_mem = 32'h11;
    step();
    n_cmp++;
    if (halt_wb !== 1'b1 || wdat_wb !== 32'h11) begin
      n_bad++;
      $display("FAIL halt_cap: halt=%b wdat=%h want 1 11", halt_wb, wdat_wb);
    end
    clr();
    mw_flush = 1;
    step();
    n_cmp++;
    if (halt_wb !== 1'b1 || RegWrite_wb !== 1'b0) begin
      n_bad++;
      $display("FAIL halt_sticky: halt=%b rw=%b want 1 0", halt_wb, RegWrite_wb);
    end
    clr();
    dREN_mem = 1;
    #1;
    n_cmp++;
    if (dmemREN !== 1'b0 || mem_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL halt_req: ren=%b stall=%b want 0 0", dmemREN, mem_stall);
    end
    step();
    n_cmp++;
    if (stall_cnt !== 32'd7) begin
      n_bad++;
      $display("FAIL halt_cnt: got %0d want 7", stall_cnt);
    end
    clr();
  endtask

  task automatic test_reset_mid();
    clr();
    nRST = 0;
    #1;
    nRST = 1;
    step();
    RegWrite_mem = 1; port_o_mem = 32'hABC; regWSEL_mem = 5'd4;
    step();
    clr();
    dREN_mem = 1; MemToReg_mem = 1; port_o_mem = 32'h100; mw_hold = 1;
    step();
    step();
    n_cmp++;
    if (stall_cnt !== 32'd2 || wdat_wb !== 32'hABC || RegWrite_wb !== 1'b1 || halt_wb !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_pre: cnt=%0d wdat=%h rw=%b halt=%b want 2 abc 1 0", stall_cnt, wdat_wb, RegWrite_wb, halt_wb);
    end
    nRST = 0;
    #1;
    n_cmp++;
    if (stall_cnt !== 32'd0 || wdat_wb !== 32'h0 || RegWrite_wb !== 1'b0 || regWSEL_wb !== 5'd0) begin
      n_bad++;
      $display("FAIL rm_async: cnt=%0d wdat=%h rw=%b sel=%0d want 0", stall_cnt, wdat_wb, RegWrite_wb, regWSEL_wb);
    end
    n_cmp++;
    if (dmemREN !== 1'b1 || mem_stall !== 1'b1) begin
      n_bad++;
      $display("FAIL rm_comb: ren=%b stall=%b want 1 1", dmemREN, mem_stall);
    end
    step();
    n_cmp++;
    if (stall_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL rm_held: cnt=%0d want 0", stall_cnt);
    end
    nRST = 1; mw_hold = 0;
    step();
    dhit = 1; dmemload = 32'h4242; RegWrite_mem = 1; regWSEL_mem = 5'd6;
    step();
    n_cmp++;
    if (stall_cnt !== 32'd1 || wdat_wb !== 32'h4242 || regWSEL_wb !== 5'd6) begin
      n_bad++;
      $display("FAIL rm_after: cnt=%0d wdat=%h sel=%0d want 1 4242 6", stall_cnt, wdat_wb, regWSEL_wb);
    end
    clr();
  endtask

  task automatic test_saturation();
    clr();
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    dREN_mem = 1;
    step();
    n_cmp++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL sat_inc: got %h want ffffffff", stall_cnt);
    end
    step();
    step();
    n_cmp++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL sat_hold: got %h want ffffffff", stall_cnt);
    end
    dhit = 1;
    step();
    clr();
  endtask

  initial begin
    nRST = 0;
    clr();
    test_reset();
    test_load_hit();
    test_store_miss();
    test_hold_hit();
    test_jal_alu();
    test_flush_dhit();
    test_flush_done();
    test_halt();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
